// File: rtl/wb_block_window_sched_if.sv
// wb_block_window_sched_if: video timing in, block/band window selects and band events out
interface wb_block_window_sched_if #(parameter int NUM_HBLK = 24);
  logic iVS;
  logic iDE;
  logic [NUM_HBLK-1:0] oH_Duty;
  logic oV_Duty;
  logic [2:0] oBandIdx;
  logic oBandDone;
  logic oFrameDone;
  logic oLineErr;
  modport master(output iVS, iDE, input oH_Duty, oV_Duty, oBandIdx, oBandDone, oFrameDone, oLineErr);
  modport slave(input iVS, iDE, output oH_Duty, oV_Duty, oBandIdx, oBandDone, oFrameDone, oLineErr);
endinterface

// File: rtl/wb_block_window_sched.sv
// wb_block_window_sched: per-pixel block and per-line band window scheduler; optional line-length check under WB_LINE_CHECK_EN
module wb_block_window_sched #(
  parameter int NUM_HBLK = 24,
  parameter int BLK_W = 80,
  parameter int NUM_VBLK = 8,
  parameter int V_LINES = 135
) (
  input logic iODCK,
  input logic iRST,
  wb_block_window_sched_if.slave bus
);
  localparam int CW = $clog2(BLK_W);
  localparam int LW = $clog2(V_LINES);
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_LINE_END} state_t;
  state_t state, stateNext;
  logic vsD, deD;
  logic [CW-1:0] col;
  logic [NUM_HBLK-1:0] blk;
  logic [LW-1:0] lineInBand;
  logic vsRise, deFall, pixel, bandEnd, frameEnd, bandDoneOk;
  assign vsRise = bus.iVS & ~vsD;
  assign deFall = ~bus.iDE & deD;
  assign pixel = state == S_ACTIVE && bus.iDE && !vsRise;
  assign bandEnd = state == S_LINE_END && !vsRise && lineInBand == LW'(V_LINES - 1);
  assign frameEnd = bandEnd && bus.oBandIdx == 3'(NUM_VBLK - 1);
`ifdef WB_LINE_CHECK_EN
  localparam int H_ACTIVE = NUM_HBLK * BLK_W;
  localparam int PW = $clog2(H_ACTIVE + 2);
  logic [PW-1:0] pixCnt;
  logic bandErr, lineErrNow;
  assign lineErrNow = state == S_LINE_END && !vsRise && pixCnt != PW'(H_ACTIVE);
  assign bandDoneOk = !(bandErr || lineErrNow);
  // count pixels per line (saturating just past a full line) and track sticky/per-band errors
  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      pixCnt <= '0;
      bandErr <= 1'b0;
      bus.oLineErr <= 1'b0;
    end else if (vsRise) begin
      pixCnt <= '0;
      bandErr <= 1'b0;
      bus.oLineErr <= 1'b0;
    end else begin
      pixCnt <= state == S_LINE_END ? '0 : (pixel && pixCnt != PW'(H_ACTIVE + 1)) ? pixCnt + 1'b1 : pixCnt;
      bus.oLineErr <= bus.oLineErr | lineErrNow;
      bandErr <= bandEnd ? 1'b0 : bandErr | lineErrNow;
    end
  end
`else
  assign bandDoneOk = 1'b1;
  assign bus.oLineErr = 1'b0;
`endif
  // state register
  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) state <= S_IDLE;
    else state <= stateNext;
  end
  // next state: a VS rise always (re)starts a frame and beats a coincident DE fall
  always_comb begin
    stateNext = state;
    if (vsRise) stateNext = S_ACTIVE;
    else if (state == S_ACTIVE && deFall) stateNext = S_LINE_END;
    else if (state == S_LINE_END) stateNext = frameEnd ? S_IDLE : S_ACTIVE;
  end
  // column/block walk, line/band counting and registered outputs
  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      vsD <= 1'b0;
      deD <= 1'b0;
      col <= '0;
      blk <= NUM_HBLK'(1);
      lineInBand <= '0;
      bus.oH_Duty <= '0;
      bus.oV_Duty <= 1'b0;
      bus.oBandIdx <= '0;
      bus.oBandDone <= 1'b0;
      bus.oFrameDone <= 1'b0;
    end else begin
      vsD <= bus.iVS;
      deD <= bus.iDE;
      bus.oH_Duty <= pixel ? blk : '0;
      bus.oV_Duty <= pixel;
      bus.oBandDone <= bandEnd && bandDoneOk;
      bus.oFrameDone <= frameEnd;
      if (vsRise || state == S_LINE_END) begin
        col <= '0;
        blk <= NUM_HBLK'(1);
      end else if (pixel && blk != '0) begin
        col <= col == CW'(BLK_W - 1) ? '0 : col + 1'b1;
        blk <= col == CW'(BLK_W - 1) ? blk << 1 : blk;
      end
      if (vsRise) begin
        lineInBand <= '0;
        bus.oBandIdx <= '0;
      end else if (state == S_LINE_END) begin
        lineInBand <= bandEnd ? '0 : lineInBand + 1'b1;
        bus.oBandIdx <= frameEnd ? '0 : bandEnd ? bus.oBandIdx + 1'b1 : bus.oBandIdx;
      end
    end
  end
endmodule

// File: tb/tb_wb_block_window_sched.sv
// tb_wb_block_window_sched: directed and random timing checked every cycle against a line/pixel-count model
module tb_wb_block_window_sched;
  localparam int NUM_HBLK = 4, BLK_W = 2, NUM_VBLK = 2, V_LINES = 2;
  localparam int H_ACTIVE = NUM_HBLK * BLK_W;
`ifdef WB_LINE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic odck = 1'b0;
  logic rstN = 1'b0;
  int nVec = 0, nErr = 0;
  wb_block_window_sched_if #(.NUM_HBLK(NUM_HBLK)) bus();
  wb_block_window_sched #(.NUM_HBLK(NUM_HBLK), .BLK_W(BLK_W), .NUM_VBLK(NUM_VBLK), .V_LINES(V_LINES))
    dut(.iODCK(odck), .iRST(rstN), .bus(bus));
  always #5 odck = ~odck;
  // model state: frame in progress, pixels in the current line, line number within the frame
  int pix = 0, lineNo = 0;
  bit active = 0, pend = 0, lerr = 0, berr = 0, pVs = 0, pDe = 0, vr, df;
  logic [3:0] eH = '0;
  logic [2:0] eIdx = '0;
  logic eV = 0, eBD = 0, eFD = 0, eLE = 0;
  logic [3:0] hExp [8] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8};
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input logic v, input logic d);
    @(negedge odck);
    bus.iVS = v;
    bus.iDE = d;
    @(posedge odck);
    #1;
  endtask
  task automatic line(input int n);
    repeat (n) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask
  initial forever begin
    @(posedge odck or negedge rstN);
    if (!rstN) begin
      {active, pend, lerr, berr, pVs, pDe} = '0;
      pix = 0;
      lineNo = 0;
      {eH, eV, eBD, eFD, eLE, eIdx} = '0;
    end else begin
      vr = bus.iVS && !pVs;
      df = !bus.iDE && pDe;
      {eH, eV, eBD, eFD} = '0;
      if (vr) begin
        active = 1; pix = 0; lineNo = 0; pend = 0; lerr = 0; berr = 0;
      end else if (active && pend) begin
        if (CHK && pix != H_ACTIVE) begin lerr = 1; berr = 1; end
        if ((lineNo + 1) % V_LINES == 0) begin eBD = !berr; berr = 0; end
        if (lineNo + 1 == NUM_VBLK * V_LINES) begin eFD = 1; active = 0; lineNo = 0; end
        else lineNo++;
        pix = 0;
        pend = 0;
      end else if (active && df) pend = 1;
      else if (active && bus.iDE) begin
        eV = 1;
        eH = pix < H_ACTIVE ? 4'(1 << (pix / BLK_W)) : 4'd0;
        pix++;
      end
      pVs = bus.iVS;
      pDe = bus.iDE;
      eIdx = 3'(lineNo / V_LINES);
      eLE = lerr;
    end
  end
  initial forever begin
    @(negedge odck);
    chk("oH_Duty", bus.oH_Duty, eH);
    chk("oV_Duty", bus.oV_Duty, eV);
    chk("oBandIdx", bus.oBandIdx, eIdx);
    chk("oBandDone", bus.oBandDone, eBD);
    chk("oFrameDone", bus.oFrameDone, eFD);
    chk("oLineErr", bus.oLineErr, eLE);
  end
  initial begin
    logic lvl;
    int left;
    bus.iVS = 0;
    bus.iDE = 0;
    repeat (4) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("lit_rstH", bus.oH_Duty, 0);
      chk("lit_rstV", bus.oV_Duty, 0);
    end
    @(negedge odck);
    bus.iVS = 0;
    bus.iDE = 0;
    rstN = 1;
    repeat (3) begin
      step(1'b0, 1'b1);
      chk("lit_idleH", bus.oH_Duty, 0);
    end
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1);
      chk("lit_hDuty", bus.oH_Duty, hExp[k]);
      chk("lit_vDuty", bus.oV_Duty, 1);
      chk("lit_bandIdx0", bus.oBandIdx, 0);
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("lit_noBandDone", bus.oBandDone, 0);
    step(1'b0, 1'b0);
    line(8);
    chk("lit_bandDone0", bus.oBandDone, 1);
    chk("lit_bandIdx1", bus.oBandIdx, 1);
    step(1'b0, 1'b0);
    chk("lit_bandDonePulse", bus.oBandDone, 0);
    line(8);
    step(1'b0, 1'b0);
    line(8);
    chk("lit_bandDone1", bus.oBandDone, 1);
    chk("lit_frameDone", bus.oFrameDone, 1);
    chk("lit_frameIdx", bus.oBandIdx, 0);
    step(1'b0, 1'b1);
    chk("lit_frameDonePulse", bus.oFrameDone, 0);
    chk("lit_afterFrameH", bus.oH_Duty, 0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1);
      if (k >= 8) chk("lit_overlongH", bus.oH_Duty, 0);
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("lit_lineErr", bus.oLineErr, 32'(CHK));
    step(1'b0, 1'b0);
    line(8);
    chk("lit_errBandDone", bus.oBandDone, 32'(!CHK));
    chk("lit_errBandIdx", bus.oBandIdx, 1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    line(8);
    step(1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("lit_abortH", bus.oH_Duty, 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("lit_abortNoBandDone", bus.oBandDone, 0);
    chk("lit_abortIdx", bus.oBandIdx, 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("lit_restartH", bus.oH_Duty, 1);
    chk("lit_restartIdx", bus.oBandIdx, 0);
    repeat (7) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("lit_vsWinsBandDone", bus.oBandDone, 0);
    step(1'b0, 1'b1);
    chk("lit_vsWinsH", bus.oH_Duty, 1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    @(negedge odck);
    bus.iDE = 1;
    @(posedge odck);
    #2;
    rstN = 0;
    #1;
    chk("lit_asyncH", bus.oH_Duty, 0);
    chk("lit_asyncV", bus.oV_Duty, 0);
    @(negedge odck);
    bus.iVS = 0;
    rstN = 1;
    step(1'b0, 1'b1);
    chk("lit_postRstIdleH", bus.oH_Duty, 0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk("lit_postRstRestartH", bus.oH_Duty, 1);
    lvl = 1'b1;
    left = 7;
    for (int i = 0; i < 3000; i++) begin
      if (left == 0) begin
        lvl = !lvl;
        left = lvl ? ($urandom_range(0, 3) == 0 ? int'($urandom_range(1, 11)) : 8) : int'($urandom_range(1, 4));
      end
      left--;
      step(1'($urandom_range(0, 59) == 0), lvl);
    end
    step(1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
